// File: rtl/ship_pkg.sv
// Shared types and screen constants for the player ship controller.
// The sprite ROM select in the renderer decodes the same state codes.
package ship_pkg;

  typedef enum logic [5:0] {
    STAND  = 6'd0,
    HIT    = 6'd1,
    MOVE_L = 6'd2,
    MOVE_R = 6'd3,
    ATTACK = 6'd4,
    DEAD   = 6'd5
  } ship_state_t;

  localparam logic [9:0] X_MIN = 10'd20;
  localparam logic [9:0] X_MAX = 10'd619;

  // Compare before subtracting so X never wraps below zero.
  function automatic logic [9:0] step_left(input logic [9:0] x, input logic [9:0] step);
    if (x < X_MIN + step) return X_MIN;
    return x - step;
  endfunction

  function automatic logic [9:0] step_right(input logic [9:0] x, input logic [9:0] step);
    if (x > X_MAX - step) return X_MAX;
    return x + step;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// one-Clk tick on each synchronized rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [1:0] fill_q;

  // While the chain refills after reset, prev follows the value sync2 is
  // about to take, so a strobe already high at release gives no tick.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b1;
      fill_q  <= 2'd2;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      if (fill_q != 2'd0) begin
        prev_q <= sync1_q;
        fill_q <= fill_q - 2'd1;
      end else begin
        prev_q <= sync2_q;
      end
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/ship_ctrl.sv
// Per-frame ship behaviour: animation FSM, hold counter, hit points and X
// position, all advanced once per synchronized frame tick.
module ship_ctrl
  import ship_pkg::*;
#(
  parameter logic [9:0] X_INIT        = 10'd320,
  parameter logic [9:0] Y_INIT        = 10'd240,
  parameter logic [9:0] STEP          = 10'd2,
  parameter logic [5:0] ATTACK_FRAMES = 6'd12,
  parameter logic [5:0] HIT_FRAMES    = 6'd8,
  parameter logic [2:0] HP_INIT       = 3'd3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       attack,
  input  logic       hit,
  output logic [5:0] ship_state,
  output logic [9:0] Ball_X_Pos,
  output logic [9:0] Ball_Y_Pos,
  output logic [2:0] hp,
  output logic       attack_start,
  output logic       is_dead
);

  // state  | meaning
  // STAND  | idle;  HIT | invulnerable stagger;  MOVE_L/R | walking
  // ATTACK | attack animation;  DEAD | frozen until reset

  logic        tick;
  ship_state_t state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [9:0]  x_q, x_d;
  logic [2:0]  hp_q, hp_d;
  logic        hit_pend_q, hit_pend_d;
  logic        attack_start_q, attack_start_d;
  logic        hit_now;
  logic [2:0]  hp_dec;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q        <= STAND;
      cnt_q          <= 6'd0;
      x_q            <= X_INIT;
      hp_q           <= HP_INIT;
      hit_pend_q     <= 1'b0;
      attack_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      x_q            <= x_d;
      hp_q           <= hp_d;
      hit_pend_q     <= hit_pend_d;
      attack_start_q <= attack_start_d;
    end
  end

  // A hit arriving on the tick cycle itself counts for that tick.
  assign hit_now = hit_pend_q | hit;
  assign hp_dec  = (hp_q == 3'd0) ? 3'd0 : hp_q - 3'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    x_d            = x_q;
    hp_d           = hp_q;
    attack_start_d = 1'b0;
    hit_pend_d     = hit_now;

    if (tick) begin
      hit_pend_d = 1'b0;
      if (state_q == DEAD) begin
        state_d = DEAD;
      end else if (hit_now && state_q != HIT) begin
        hp_d = hp_dec;
        if (hp_dec == 3'd0) begin
          state_d = DEAD;
          cnt_d   = 6'd0;
        end else begin
          state_d = HIT;
          cnt_d   = HIT_FRAMES - 6'd1;
        end
      end else if (state_q == HIT || state_q == ATTACK) begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = STAND;
        end
      end else if (attack) begin
        state_d        = ATTACK;
        cnt_d          = ATTACK_FRAMES - 6'd1;
        attack_start_d = 1'b1;
      end else if (move_left ^ move_right) begin
        state_d = move_left ? MOVE_L : MOVE_R;
      end else begin
        state_d = STAND;
      end

      if (state_d == MOVE_L) begin
        x_d = step_left(x_q, STEP);
      end else if (state_d == MOVE_R) begin
        x_d = step_right(x_q, STEP);
      end
    end
  end

  assign ship_state   = state_q;
  assign Ball_X_Pos   = x_q;
  assign Ball_Y_Pos   = Y_INIT;
  assign hp           = hp_q;
  assign attack_start = attack_start_q;
  assign is_dead      = (state_q == DEAD);

endmodule
